// File: rtl/ddr3_burst_arbiter.sv
// Round-robin write/read burst arbiter between a frame FIFO pair and a DDR3 MIG user port.
// Ping-pong frame banks are selected by one address bit; frame loads take effect only in IDLE.
module ddr3_burst_arbiter #(
  parameter int ADDR_W   = 29,
  parameter int CNT_W    = 10,
  parameter int BEAT_INC = 8,
  parameter int RD_DEPTH = 512,
  parameter int BANK_BIT = 24
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] app_addr_min,
  input  logic [ADDR_W-1:0] app_addr_max,
  input  logic [7:0]        burst_len,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  output logic              wr_fifo_rden,
  input  logic [CNT_W-1:0]  rd_fifo_cnt,
  output logic              rd_fifo_wren,
  output logic [2:0]        app_cmd,
  output logic              app_cmd_en,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;

  localparam logic [ADDR_W-1:0] BANK_MASK  = ADDR_W'(1) << BANK_BIT;
  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(BEAT_INC);
  localparam logic [31:0]       RD_DEPTH_U = 32'(RD_DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        beat_cnt, beat_cnt_nxt, len_q;
  logic              armed, last_rd;
  logic              wr_bank, rd_bank, prev_bank;
  logic              wr_pend, rd_pend;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_req, rd_req, wr_beat, rd_acc, last_beat;
  logic              wr_apply, rd_apply, start_wr, start_rd;

  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] ptr,
                                                input logic [ADDR_W-1:0] lo,
                                                input logic [ADDR_W-1:0] hi);
    logic [ADDR_W-1:0] sum;
    sum = ptr + INC;
    return (sum >= hi) ? lo : sum;
  endfunction

  // Read request rewritten as cnt + len <= depth so it cannot underflow.
  assign wr_req    = 32'(wr_fifo_cnt) >= 32'(burst_len);
  assign rd_req    = (32'(rd_fifo_cnt) + 32'(burst_len)) <= RD_DEPTH_U;
  assign wr_beat   = (state == WR_BURST) && app_rdy && app_wdf_rdy;
  assign rd_acc    = (state == RD_CMD) && app_rdy;
  assign last_beat = (beat_cnt == (len_q - 8'd1));
  assign wr_apply  = (state == IDLE) && (wr_pend || wr_load);
  assign rd_apply  = (state == IDLE) && (rd_pend || rd_load);

  assign rd_fifo_wren = app_rd_data_valid;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    start_wr     = 1'b0;
    start_rd     = 1'b0;
    app_cmd_en   = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wr_fifo_rden = 1'b0;
    case (state)
      IDLE: begin
        beat_cnt_nxt = 8'd0;
        // armed delays the first decision to the second edge after reset release
        if (armed && init_calib_complete) begin
          if (wr_req && (!rd_req || last_rd)) begin
            start_wr  = 1'b1;
            state_nxt = WR_BURST;
          end else if (rd_req) begin
            start_rd  = 1'b1;
            state_nxt = RD_CMD;
          end
        end
      end
      WR_BURST: begin
        app_cmd_en   = 1'b1;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_addr     = wr_ptr | (wr_bank ? BANK_MASK : '0);
        if (wr_beat) begin
          wr_fifo_rden = 1'b1;
          if (last_beat) begin
            beat_cnt_nxt = 8'd0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      RD_CMD: begin
        app_cmd_en = 1'b1;
        app_cmd    = 3'd1;
        app_addr   = rd_ptr | (rd_bank ? BANK_MASK : '0);
        if (rd_acc) begin
          if (last_beat) begin
            beat_cnt_nxt = 8'd0;
            state_nxt    = RD_WAIT;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          if (last_beat) begin
            beat_cnt_nxt = 8'd0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A simultaneous rd_load takes the write bank as it stood before this toggle.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      beat_cnt  <= 8'd0;
      len_q     <= 8'd0;
      armed     <= 1'b0;
      last_rd   <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      prev_bank <= 1'b0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      armed    <= 1'b1;
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (start_wr || start_rd) len_q <= burst_len;
      if (start_wr) last_rd <= 1'b0;
      else if (start_rd) last_rd <= 1'b1;
      wr_pend <= (state != IDLE) && (wr_pend || wr_load);
      rd_pend <= (state != IDLE) && (rd_pend || rd_load);
      if (wr_apply) begin
        wr_bank   <= ~wr_bank;
        prev_bank <= wr_bank;
        wr_ptr    <= app_addr_min;
      end else if (wr_beat) begin
        wr_ptr <= advance(wr_ptr, app_addr_min, app_addr_max);
      end
      if (rd_apply) begin
        rd_bank <= wr_apply ? wr_bank : prev_bank;
        rd_ptr  <= app_addr_min;
      end else if (rd_acc) begin
        rd_ptr <= advance(rd_ptr, app_addr_min, app_addr_max);
      end
    end
  end

endmodule
